bus_cycle_controller: RTL

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

---
 rtl/bus_cycle_controller_if.sv | 25 ++
 rtl/bus_cycle_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bus_cycle_controller_if.sv
// CPU-side bus signals between the 68k-style bus master and the cycle controller.
// The master drives strobes/selects; the controller returns the acknowledges.
interface bus_cycle_controller_if;
  logic as_n;
  logic cpu_space;
  logic sel_rom;
  logic sel_sram;
  logic sel_duart;
  logic sel_ide;
  logic dtack_duart_n;
  logic dsack0_n;
  logic dsack1_n;
  logic berr_n;
  logic busy;

  modport master (
    output as_n, cpu_space, sel_rom, sel_sram, sel_duart, sel_ide, dtack_duart_n,
    input  dsack0_n, dsack1_n, berr_n, busy
  );

  modport slave (
    input  as_n, cpu_space, sel_rom, sel_sram, sel_duart, sel_ide, dtack_duart_n,
    output dsack0_n, dsack1_n, berr_n, busy
  );
endinterface

// File: rtl/bus_cycle_controller.sv
// Bus cycle controller: counts wait states per decoded region and terminates each
// CPU cycle with DSACK0/DSACK1 or, on timeout, with a bus error.
module bus_cycle_controller #(
  parameter int unsigned ROM_WAIT  = 3,
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned IDE_WAIT  = 6,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  bus_cycle_controller_if.slave     bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] ROM_WAIT_C  = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] SRAM_WAIT_C = CNT_W'(SRAM_WAIT);
  localparam logic [CNT_W-1:0] IDE_WAIT_C  = CNT_W'(IDE_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ACK   = 2'd2,
    BERR  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    REG_NONE  = 3'd0,
    REG_ROM   = 3'd1,
    REG_SRAM  = 3'd2,
    REG_DUART = 3'd3,
    REG_IDE   = 3'd4
  } region_e;

  state_e           state_q, state_d;
  region_e          region_q, region_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dsack0_q, dsack0_d;
  logic             dsack1_q, dsack1_d;
  logic             berr_q, berr_d;
  logic             busy_q, busy_d;

  region_e          region_sel_c;
  logic             ack_hit_c;

  // Priority decode of the selects; CPU space cycles never match a device.
  always_comb begin
    region_sel_c = REG_NONE;
    if (!bus.cpu_space) begin
      if (bus.sel_ide)        region_sel_c = REG_IDE;
      else if (bus.sel_duart) region_sel_c = REG_DUART;
      else if (bus.sel_sram)  region_sel_c = REG_SRAM;
      else if (bus.sel_rom)   region_sel_c = REG_ROM;
      else                    region_sel_c = REG_NONE;
    end
  end

  // Acknowledge condition for the region latched at cycle start.
  always_comb begin
    ack_hit_c = 1'b0;
    case (region_q)
      REG_ROM:   ack_hit_c = (cnt_q == ROM_WAIT_C);
      REG_SRAM:  ack_hit_c = (cnt_q == SRAM_WAIT_C);
      REG_IDE:   ack_hit_c = (cnt_q == IDE_WAIT_C);
      REG_DUART: ack_hit_c = !bus.dtack_duart_n;
      default:   ack_hit_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic; AS_n release outranks ACK, ACK outranks BERR.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    dsack0_d = 1'b1;
    dsack1_d = 1'b1;
    berr_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!bus.as_n) begin
          state_d  = COUNT;
          cnt_d    = '0;
          region_d = region_sel_c;
        end
      end

      COUNT: begin
        if (bus.as_n) begin
          state_d = IDLE;
        end else if (ack_hit_c) begin
          state_d = ACK;
          if (region_q == REG_IDE) dsack1_d = 1'b0;
          else                     dsack0_d = 1'b0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = BERR;
          berr_d  = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end

      ACK: begin
        if (bus.as_n) begin
          state_d = IDLE;
        end else begin
          dsack0_d = dsack0_q;
          dsack1_d = dsack1_q;
        end
      end

      BERR: begin
        if (bus.as_n) state_d = IDLE;
        else          berr_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      region_q <= REG_NONE;
      cnt_q    <= '0;
      dsack0_q <= 1'b1;
      dsack1_q <= 1'b1;
      berr_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      dsack0_q <= dsack0_d;
      dsack1_q <= dsack1_d;
      berr_q   <= berr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.dsack0_n = dsack0_q;
  assign bus.dsack1_n = dsack1_q;
  assign bus.berr_n   = berr_q;
  assign bus.busy     = busy_q;

endmodule
